// File: rtl/tdes_pkg.sv
// tdes_pkg: shared types and constants for the Triple-DES pass sequencer.
//   state_t      - sequencer FSM states
//   block_t      - one 64-bit DES block
//   ROUNDS       - DES rounds per pass
//   PASSES       - DES passes per Triple-DES block
//   pass_key_idx - which user key (0 = key_one, 1 = key_two, 2 = key_three) a pass uses
//   pass_decrypt - direction of a pass (1 = decrypt)
package tdes_pkg;

  localparam int ROUNDS = 16;
  localparam int PASSES = 3;

  typedef logic [63:0] block_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    ROUND    = 2'd2,
    WAIT_OUT = 2'd3
  } state_t;

  // Key index per pass, two bits per pass, pass 0 in the LSBs.
  // Encrypt: k1, k2, k3.  Decrypt: k3, k2, k1.
  localparam logic [5:0] ENC_KEY_IDX = {2'd2, 2'd1, 2'd0};
  localparam logic [5:0] DEC_KEY_IDX = {2'd0, 2'd1, 2'd2};

  // Direction per pass, 1 = decrypt, pass 0 in bit 0.
  // Encrypt: E, D, E.  Decrypt: D, E, D.
  localparam logic [2:0] ENC_DIR = 3'b010;
  localparam logic [2:0] DEC_DIR = 3'b101;

  function automatic logic [1:0] pass_key_idx(input logic [1:0] p, input logic enc);
    logic [5:0] tbl;
    logic [1:0] idx;
    tbl = enc ? ENC_KEY_IDX : DEC_KEY_IDX;
    case (p)
      2'd0:    idx = tbl[1:0];
      2'd1:    idx = tbl[3:2];
      default: idx = tbl[5:4];
    endcase
    return idx;
  endfunction

  function automatic logic pass_decrypt(input logic [1:0] p, input logic enc);
    logic [2:0] tbl;
    logic       dir;
    tbl = enc ? ENC_DIR : DEC_DIR;
    case (p)
      2'd0:    dir = tbl[0];
      2'd1:    dir = tbl[1];
      default: dir = tbl[2];
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/tdes_pass_sequencer_if.sv
// tdes_pass_sequencer_if: block stream between the register file and the sequencer.
//   in_valid/in_ready/in_data/in_enc     - input block handshake, in_enc 1 = encrypt
//   out_valid/out_ready/out_data         - result handshake
// Handshake: a transfer happens on a rising clock edge where valid && ready are both 1.
// The producer holds valid and its payload stable until the transfer; the sequencer
// keeps out_data stable while out_valid && !out_ready.
// Modports: master = register file side, slave = sequencer side.
interface tdes_pass_sequencer_if;
  import tdes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  block_t in_data;
  logic   in_enc;
  logic   out_valid;
  logic   out_ready;
  block_t out_data;

  modport master (
    output in_valid, in_data, in_enc, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_enc, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/tdes_key_bank.sv
// tdes_key_bank: staged and active Triple-DES key sets.
//   HCLK, HRESET                 - clock, synchronous active-low reset
//   key_load, key_one..three     - write the staged set and raise key_pending
//   commit                       - sequencer idle with an empty buffer: staged -> active
//   pass, enc                    - pass index and mode of the block in flight
//   key, decrypt                 - active key and direction for that pass
//   key_pending                  - staged set differs from the active one
module tdes_key_bank
  import tdes_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       key_load,
  input  block_t     key_one,
  input  block_t     key_two,
  input  block_t     key_three,
  input  logic       commit,
  input  logic [1:0] pass,
  input  logic       enc,
  output block_t     key,
  output logic       decrypt,
  output logic       key_pending
);

  block_t stg_one, stg_two, stg_three;
  block_t act_one, act_two, act_three;

  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      stg_one     <= '0;
      stg_two     <= '0;
      stg_three   <= '0;
      act_one     <= '0;
      act_two     <= '0;
      act_three   <= '0;
      key_pending <= 1'b0;
    end else begin
      if (key_load) begin
        stg_one   <= key_one;
        stg_two   <= key_two;
        stg_three <= key_three;
      end
      // A commit coinciding with a new key_load copies the previous staged
      // set; key_pending stays up so the new set is copied on the next commit.
      if (commit && key_pending) begin
        act_one   <= stg_one;
        act_two   <= stg_two;
        act_three <= stg_three;
      end
      if (key_load) begin
        key_pending <= 1'b1;
      end else if (commit) begin
        key_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    key = act_three;
    case (pass_key_idx(pass, enc))
      2'd0:    key = act_one;
      2'd1:    key = act_two;
      default: key = act_three;
    endcase
    decrypt = pass_decrypt(pass, enc);
  end

endmodule

// File: rtl/tdes_pass_sequencer.sv
// tdes_pass_sequencer: runs one block through PASSES passes of an iterative
// single-DES round core to form a Triple-DES encrypt/decrypt result.
//   HCLK, HRESET           - clock, synchronous active-low reset
//   key_load, key_one..3   - stage a new key set, applied at a block boundary
//   host                   - input/output block stream (slave side)
//   core_load/core_block   - core latches core_block this cycle
//   core_step/core_round   - core executes round core_round this cycle
//   core_key/core_decrypt  - key and direction of the current pass
//   core_result            - core state
//   busy                   - block in flight, buffered, or result held
//   dbg_state              - FSM state
// core_result must show the post-round value during a core_step cycle (and the
// held state otherwise): the final result is latched at the end of the last
// round cycle, and in WAIT_OUT the core holds that value with core_step low.
module tdes_pass_sequencer
  import tdes_pkg::*;
#(
  parameter int ROUNDS = tdes_pkg::ROUNDS,
  parameter int PASSES = tdes_pkg::PASSES
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                key_load,
  input  block_t              key_one,
  input  block_t              key_two,
  input  block_t              key_three,
  tdes_pass_sequencer_if.slave host,
  output logic                core_load,
  output block_t              core_block,
  output logic                core_step,
  output logic [3:0]          core_round,
  output block_t              core_key,
  output logic                core_decrypt,
  input  block_t              core_result,
  output logic                busy,
  output state_t              dbg_state
);

  state_t     state, state_next;
  logic [1:0] p;
  logic [3:0] r;

  logic   buf_full;
  block_t buf_data;
  logic   buf_enc;
  logic   cur_enc;
  logic   out_valid_q;
  block_t out_data_q;

  logic   in_ready;
  logic   key_pending;
  block_t bank_key;
  logic   bank_decrypt;

  logic out_free, last_round, last_pass, accept, buf_release, latch_result;

  assign out_free    = !out_valid_q || host.out_ready;
  assign last_round  = (r == 4'(ROUNDS - 1));
  assign last_pass   = (p == 2'(PASSES - 1));
  assign accept      = host.in_valid && in_ready;
  assign buf_release = (state == LOAD) && (p == 2'd0);
  // Final result enters the output register straight from the last round
  // or, after backpressure, on the first free cycle in WAIT_OUT.
  assign latch_result = out_free &&
                        (((state == ROUND) && last_round && last_pass) ||
                         (state == WAIT_OUT));

  tdes_key_bank u_key_bank (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .key_load    (key_load),
    .key_one     (key_one),
    .key_two     (key_two),
    .key_three   (key_three),
    .commit      ((state == IDLE) && !buf_full),
    .pass        (p),
    .enc         (cur_enc),
    .key         (bank_key),
    .decrypt     (bank_decrypt),
    .key_pending (key_pending)
  );

  // State register
  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (buf_full) state_next = LOAD;
      end
      LOAD: begin
        state_next = ROUND;
      end
      ROUND: begin
        if (last_round) begin
          if (!last_pass)     state_next = LOAD;
          else if (!out_free) state_next = WAIT_OUT;
          else                state_next = buf_full ? LOAD : IDLE;
        end
      end
      WAIT_OUT: begin
        if (out_free) state_next = buf_full ? LOAD : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    core_load  = (state == LOAD);
    core_block = '0;
    if (state == LOAD) begin
      core_block = (p == 2'd0) ? buf_data : core_result;
    end
    core_step    = (state == ROUND);
    core_round   = core_step ? r : 4'd0;
    core_key     = core_step ? bank_key : '0;
    core_decrypt = core_step && bank_decrypt;
    in_ready     = !buf_full && !key_pending;
    busy         = (state != IDLE) || buf_full || out_valid_q;
  end

  // Pass and round counters. p returns to 0 when a block finishes so a
  // back-to-back LOAD starts from the buffered block.
  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      p <= 2'd0;
      r <= 4'd0;
    end else begin
      case (state)
        IDLE: p <= 2'd0;
        LOAD: r <= 4'd0;
        ROUND: begin
          if (last_round) begin
            r <= 4'd0;
            p <= last_pass ? 2'd0 : p + 2'd1;
          end else begin
            r <= r + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Input buffer, block mode and output register
  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      buf_full    <= 1'b0;
      buf_data    <= '0;
      buf_enc     <= 1'b0;
      cur_enc     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (accept) begin
        buf_full <= 1'b1;
        buf_data <= host.in_data;
        buf_enc  <= host.in_enc;
      end else if (buf_release) begin
        buf_full <= 1'b0;
      end
      if (buf_release) begin
        cur_enc <= buf_enc;
      end
      if (latch_result) begin
        out_valid_q <= 1'b1;
        out_data_q  <= core_result;
      end else if (host.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign host.in_ready  = in_ready;
  assign host.out_valid = out_valid_q;
  assign host.out_data  = out_data_q;
  assign dbg_state      = state;

endmodule
